conv_window_pingpong: RTL
=========================

# conv_window_pingpong

Parametrised double-buffered line store for the convolution datapath, generalising the fixed 3-row/4-column two-bank buffer to KERNEL rows, COLUMNS columns and a proper valid/ready handshake on both sides. The upstream image reader writes one KERNEL-pixel column per handshake into the bank currently filling. The downstream MAC array receives complete KERNEL×KERNEL windows from the other bank. Banks swap automatically, so filling and draining overlap without wrap-around windows.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- KERNEL, 3, window size; also rows per bank (≥2)
- COLUMNS, 8, columns per bank (≥ KERNEL)
- CW, $clog2(COLUMNS), column counter width (derived, not overridden)
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous clear of both banks, counters and output; priority over all handshakes
- in_valid  in  1  input column valid
- in_ready  out  1  buffer can accept a column
- in_col  in  KERNEL*DATA_WIDTH  column; row r at [r*DATA_WIDTH +: DATA_WIDTH]
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts window
- win_data  out  KERNEL*KERNEL*DATA_WIDTH  element (r,c) at [(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH]
- win_last  out  1  last window of current bank
- win_bank  out  1  bank the window came from
- bank_full  out  2  per-bank FULL/READING flag, for debug and performance counters

## Operation
- Storage: mem[bank][row][col], 2×KERNEL×COLUMNS words. Not reset; contents undefined until written.
- Per-bank FSM, states EMPTY → FILLING → FULL → READING → EMPTY.
  - EMPTY→FILLING on the first accepted write.
  - FILLING→FULL on the accepted write with wr_col==COLUMNS-1.
  - FULL→READING when the reader selects the bank.
  - READING→EMPTY on the handshake of the last window.
- Writer: wr_bank, wr_col. in_ready = state[wr_bank] ∈ {EMPTY, FILLING} (combinational from registered state). On in_valid&&in_ready, mem[wr_bank][r][wr_col] ← in_col row r and wr_col increments. At COLUMNS-1, wr_col→0 and wr_bank toggles.
- Reader: rd_bank, rd_col (window base, 0..COLUMNS-KERNEL). WPB = COLUMNS-KERNEL+1 windows per bank, no modulo wrap. Output register loads win_data = mem[rd_bank][r][rd_col+c] when (!win_valid || win_ready) and state[rd_bank] ∈ {FULL, READING}.
- On the handshake with win_last=1, rd_bank toggles, rd_col→0 and the bank goes EMPTY.
- Banks are consumed in fill order: bank 0 first after reset, then strict alternation.
- flush or reset: all banks EMPTY, wr_bank=rd_bank=0, counters 0.

## Timing
- Reset values: in_ready=1, win_valid=0, win_data=0, win_last=0, win_bank=0, bank_full=2'b00.
- Fill-to-output latency: the last column is written at edge N (bank FULL after N). win_valid=1 with window 0 after edge N+1.
- Throughput: one window per cycle while win_ready=1. One column per cycle while in_ready=1.
- Stall: with win_valid=1 and win_ready=0, win_data, win_last and win_bank hold stable and rd_col does not advance.
- Bank change: the last window of bank A is accepted at edge M. If bank B is FULL, window 0 of B is valid after the same edge M, with no bubble.
- Freed bank: it is EMPTY after edge M, so in_ready may rise in the cycle after M. A write cannot land in a bank during the cycle it is freed.
- Both banks FULL/READING: in_ready=0. Upstream stalls until a bank is released.
- Simultaneous write and read act on different banks by construction; no interaction.
- Reset or flush mid-window drops the window (win_valid→0) and all partially written data.

## Test plan
- Reset, then 8 columns with in_col={r=2:8'h2c,r=1:8'h1c,r=0:8'h0c} for c=0..7, win_ready=1 → 6 windows on consecutive cycles, first valid 1 cycle after the 8th write. Window 0: (0,0)=8'h00, (2,2)=8'h22. Window 5: (0,0)=8'h05. win_last only on window 5. win_bank=0.
- Continuous input, 16 columns back-to-back, win_ready=1 → 12 windows. win_bank switches 0→1 with no idle cycle between window 5 and window 6. in_ready stays 1 throughout.
- win_ready=0 for 5 cycles during window 2 → win_data constant, window 3 follows only after win_ready=1. No window lost or duplicated.
- win_ready=0 permanently, 24 columns offered → in_ready falls after the 16th accepted column. bank_full=2'b11. Input is held without loss until win_ready=1, then 12 windows emerge in order.
- flush asserted after 5 columns → in_ready=1, win_valid=0 and bank_full=0 next cycle. A fresh 8-column fill yields window 0 from the new data.
- Async reset pulse while win_valid=1 → outputs take reset values immediately without a clock edge. Operation resumes cleanly from bank 0.

Source files
------------

// File: rtl/conv_window_pingpong.sv
// Double-buffered line store: upstream fills one bank column by column while the
// other bank is drained as KERNEL x KERNEL windows; banks swap automatically.
module conv_window_pingpong #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int COLUMNS    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [KERNEL*DATA_WIDTH-1:0]         in_col,
  output logic                                 win_valid,
  input  logic                                 win_ready,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  win_data,
  output logic                                 win_last,
  output logic                                 win_bank,
  output logic [1:0]                           bank_full
);

  localparam int CW    = $clog2(COLUMNS);
  localparam int WIN_W = KERNEL*KERNEL*DATA_WIDTH;
  localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS-1);
  localparam logic [CW-1:0] LAST_WIN = CW'(COLUMNS-KERNEL);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  function automatic logic bank_busy(input bank_state_t s);
    return (s == FULL) || (s == READING);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [2][KERNEL][COLUMNS];

  bank_state_t       state_r [2];
  bank_state_t       state_next_s [2];
  logic              wr_bank_r, wr_bank_next_s;
  logic [CW-1:0]     wr_col_r, wr_col_next_s;
  // rd_bank_r/rd_col_r point at the next window to load, so the pointer moves
  // to the other bank as soon as the last window is loaded (no bubble on swap).
  logic              rd_bank_r, rd_bank_next_s;
  logic [CW-1:0]     rd_col_r, rd_col_next_s;
  logic              win_valid_r, win_valid_next_s;
  logic [WIN_W-1:0]  win_data_r, win_data_next_s, win_gather_s;
  logic              win_last_r, win_last_next_s;
  logic              win_bank_r, win_bank_next_s;
  logic              in_ready_s, in_fire_s, out_fire_s, load_s, rd_last_s;

  // Next-state logic for pointers, bank FSMs and the output register.
  always_comb begin
    in_ready_s       = !bank_busy(state_r[wr_bank_r]);
    in_fire_s        = in_valid && in_ready_s;
    out_fire_s       = win_valid_r && win_ready;
    load_s           = (!win_valid_r || win_ready) && bank_busy(state_r[rd_bank_r]);
    rd_last_s        = (rd_col_r == LAST_WIN);
    wr_bank_next_s   = wr_bank_r;
    wr_col_next_s    = wr_col_r;
    rd_bank_next_s   = rd_bank_r;
    rd_col_next_s    = rd_col_r;
    win_valid_next_s = win_valid_r;
    win_data_next_s  = win_data_r;
    win_last_next_s  = win_last_r;
    win_bank_next_s  = win_bank_r;
    win_gather_s     = {WIN_W{1'b0}};

    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_gather_s[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_bank_r][r][rd_col_r + CW'(c)];
      end
    end

    if (in_fire_s) begin
      if (wr_col_r == LAST_COL) begin
        wr_col_next_s  = {CW{1'b0}};
        wr_bank_next_s = !wr_bank_r;
      end else begin
        wr_col_next_s  = wr_col_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      wr_col_next_s = wr_col_r;
    end

    if (load_s) begin
      win_valid_next_s = 1'b1;
      win_data_next_s  = win_gather_s;
      win_last_next_s  = rd_last_s;
      win_bank_next_s  = rd_bank_r;
      if (rd_last_s) begin
        rd_col_next_s  = {CW{1'b0}};
        rd_bank_next_s = !rd_bank_r;
      end else begin
        rd_col_next_s  = rd_col_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (out_fire_s) begin
      win_valid_next_s = 1'b0;
    end else begin
      win_valid_next_s = win_valid_r;
    end

    for (int b = 0; b < 2; b++) begin
      state_next_s[b] = state_r[b];
      case (state_r[b])
        EMPTY: begin
          if (in_fire_s && (wr_bank_r == 1'(b))) begin
            state_next_s[b] = (wr_col_r == LAST_COL) ? FULL : FILLING;
          end else begin
            state_next_s[b] = EMPTY;
          end
        end
        FILLING: begin
          if (in_fire_s && (wr_bank_r == 1'(b)) && (wr_col_r == LAST_COL)) begin
            state_next_s[b] = FULL;
          end else begin
            state_next_s[b] = FILLING;
          end
        end
        FULL: begin
          if (load_s && (rd_bank_r == 1'(b))) begin
            state_next_s[b] = READING;
          end else begin
            state_next_s[b] = FULL;
          end
        end
        READING: begin
          if (out_fire_s && win_last_r && (win_bank_r == 1'(b))) begin
            state_next_s[b] = EMPTY;
          end else begin
            state_next_s[b] = READING;
          end
        end
        default: state_next_s[b] = EMPTY;
      endcase
    end
  end

  // Control and output registers with async reset and synchronous flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) state_r[b] <= EMPTY;
      wr_bank_r   <= 1'b0;
      wr_col_r    <= {CW{1'b0}};
      rd_bank_r   <= 1'b0;
      rd_col_r    <= {CW{1'b0}};
      win_valid_r <= 1'b0;
      win_data_r  <= {WIN_W{1'b0}};
      win_last_r  <= 1'b0;
      win_bank_r  <= 1'b0;
    end else if (flush) begin
      for (int b = 0; b < 2; b++) state_r[b] <= EMPTY;
      wr_bank_r   <= 1'b0;
      wr_col_r    <= {CW{1'b0}};
      rd_bank_r   <= 1'b0;
      rd_col_r    <= {CW{1'b0}};
      win_valid_r <= 1'b0;
      win_data_r  <= {WIN_W{1'b0}};
      win_last_r  <= 1'b0;
      win_bank_r  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) state_r[b] <= state_next_s[b];
      wr_bank_r   <= wr_bank_next_s;
      wr_col_r    <= wr_col_next_s;
      rd_bank_r   <= rd_bank_next_s;
      rd_col_r    <= rd_col_next_s;
      win_valid_r <= win_valid_next_s;
      win_data_r  <= win_data_next_s;
      win_last_r  <= win_last_next_s;
      win_bank_r  <= win_bank_next_s;
    end
  end

  // Column storage; not reset, a write during flush is dropped.
  always_ff @(posedge clk) begin
    if (in_fire_s && !flush) begin
      for (int r = 0; r < KERNEL; r++) begin
        mem_r[wr_bank_r][r][wr_col_r] <= in_col[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign win_valid = win_valid_r;
  assign win_data  = win_data_r;
  assign win_last  = win_last_r;
  assign win_bank  = win_bank_r;
  assign bank_full = {bank_busy(state_r[1]), bank_busy(state_r[0])};

endmodule
